mmr_register_scrubbed: RTL
==========================

MMR_REGISTER_SCRUBBED -- requirements
Module: mmr_register_scrubbed

Interface
REQ-001 SHALL have parameter K_MMR, default 3: number of redundant copies; odd, >= 3.
REQ-002 SHALL have parameter WIDTH, default 8: bits per copy.
REQ-003 SHALL have parameter RESET_VALUE, default 0: WIDTH-bit value loaded into every copy on reset.
REQ-004 SHALL have parameter SCRUB_PERIOD, default 16: cycles between periodic scrubs; >= 2.
REQ-005 SHALL have parameter CNT_WIDTH, default 8: width of the correction counter.
REQ-006 SHALL have port clk_i, input, 1: the single clock; all state on rising edge.
REQ-007 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port wr_en_i, input, 1: write strobe.
REQ-009 SHALL have port wr_data_i, input, WIDTH: write data, loaded into all copies.
REQ-010 SHALL have port scrub_req_i, input, 1: forced-scrub request, level.
REQ-011 SHALL have port scrub_ack_o, output, 1: one-cycle pulse when the forced scrub is done.
REQ-012 SHALL have port fault_inj_en_i, input, 1: fault-injection strobe.
REQ-013 SHALL have port fault_inj_mask_i, input, K_MMR*WIDTH: XOR mask; copy k uses bits [k*WIDTH +: WIDTH].
REQ-014 SHALL have port data_o, output, K_MMR*WIDTH: raw copies, same packing; feeds downstream voters.
REQ-015 SHALL have port voted_o, output, WIDTH: bitwise majority of the copies.
REQ-016 SHALL have port mismatch_o, output, 1: registered flag, any copy differs from voted value.
REQ-017 SHALL have port corr_cnt_o, output, CNT_WIDTH: count of scrubs that corrected a mismatch.
REQ-018 SHALL have port cnt_clr_i, input, 1: synchronous clear of corr_cnt_o.

Function
REQ-019 voted_o bit b SHALL be 1 iff more than K_MMR/2 copies have bit b = 1; combinational from copies.
REQ-020 Per-edge update priority SHALL be: write > scrub > fault injection; only one applies per edge.
REQ-021 Write: wr_en_i high at edge N SHALL make every copy equal wr_data_i from N+1.
REQ-022 Scrub: at a scrub edge every copy SHALL load the pre-edge voted_o value.
REQ-023 Fault injection: when it applies, each copy SHALL load copy XOR its mask slice.
REQ-024 Period counter SHALL count 0..SCRUB_PERIOD-1 and wrap to 0.
REQ-025 At terminal count SHALL schedule a periodic scrub for that edge.
REQ-026 A scheduled scrub blocked by a write SHALL stay pending and run on the next non-write edge.
REQ-027 A forced scrub SHALL run on the first edge with scrub_req_i high and no write.
REQ-028 A forced scrub SHALL reset the period counter to 0.
REQ-029 scrub_ack_o SHALL be high for exactly the one cycle after a forced scrub edge.
REQ-030 If scrub_req_i is still high in the cycle after the ack, SHALL start a new request.
REQ-031 Periodic and forced scrub on the same edge SHALL merge into one scrub, with ack and counter reset.
REQ-032 mismatch_o SHALL be registered, high in cycle N+1 iff copies differ at edge N.
REQ-033 corr_cnt_o SHALL increment by 1 at a scrub edge only if copies differ at that edge.
REQ-034 corr_cnt_o SHALL saturate at 2^CNT_WIDTH-1.
REQ-035 cnt_clr_i SHALL take priority over increment and set corr_cnt_o to 0 next cycle.

Reset
REQ-036 rst_i high SHALL immediately set: all copies to RESET_VALUE, period counter 0, pending scrub cleared.
REQ-037 rst_i high SHALL immediately set: scrub_ack_o 0, mismatch_o 0, corr_cnt_o 0.
REQ-038 A forced request in progress when rst_i asserts SHALL be dropped.
REQ-039 After rst_i deasserts, a still-high scrub_req_i SHALL be treated as a new request.

Verification
REQ-040 Reset with RESET_VALUE=0x5A -> data_o=0x5A5A5A, voted_o=0x5A, mismatch_o=0, corr_cnt_o=0.
REQ-041 Write 0x3C; inject mask 0x000100 -> data_o=0x3C3D3C, voted_o=0x3C, mismatch_o=1 next cycle.
REQ-042 Continue REQ-041 to terminal count -> data_o=0x3C3C3C, corr_cnt_o=1, mismatch_o=0 the cycle after.
REQ-043 scrub_req_i with wr_en_i high for 3 cycles -> scrub on 4th edge, scrub_ack_o pulse next cycle, period counter 0.
REQ-044 Inject then scrub repeatedly with CNT_WIDTH=2 -> corr_cnt_o stops at 3.
REQ-045 cnt_clr_i on a correcting scrub edge -> corr_cnt_o=0.
REQ-046 Write and inject on the same edge -> write value in all copies, mismatch_o=0.

Source files
------------

// File: rtl/mmr_register_scrubbed.sv
// -----------------------------------------------------------------------------
// mmr_register_scrubbed
//
// Register kept as K_MMR redundant copies with a bitwise majority voter,
// periodic and on-demand scrubbing (rewrite every copy with the voted value),
// and a fault-injection port for exercising the redundancy.
//
// Ports
//   clk_i             single clock, all state on the rising edge
//   rst_i             asynchronous, active-high reset
//   wr_en_i           write strobe; wr_data_i is loaded into every copy
//   wr_data_i         write data (WIDTH)
//   scrub_req_i       forced-scrub request (level)
//   scrub_ack_o       one-cycle pulse in the cycle after a forced scrub edge
//   fault_inj_en_i    fault-injection strobe
//   fault_inj_mask_i  XOR mask, copy k uses bits [k*WIDTH +: WIDTH]
//   data_o            raw copies, same packing as the mask
//   voted_o           bitwise majority of the copies
//   mismatch_o        registered: some copy differed from the vote last edge
//   corr_cnt_o        saturating count of scrubs that repaired a mismatch
//   cnt_clr_i         synchronous clear of corr_cnt_o
//
// Edge priority: write > scrub > fault injection; only one touches the copies.
// -----------------------------------------------------------------------------
module mmr_register_scrubbed #(
  parameter int unsigned       K_MMR        = 3,
  parameter int unsigned       WIDTH        = 8,
  parameter logic [WIDTH-1:0]  RESET_VALUE  = '0,
  parameter int unsigned       SCRUB_PERIOD = 16,
  parameter int unsigned       CNT_WIDTH    = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     scrub_req_i,
  output logic                     scrub_ack_o,
  input  logic                     fault_inj_en_i,
  input  logic [K_MMR*WIDTH-1:0]   fault_inj_mask_i,
  output logic [K_MMR*WIDTH-1:0]   data_o,
  output logic [WIDTH-1:0]         voted_o,
  output logic                     mismatch_o,
  output logic [CNT_WIDTH-1:0]     corr_cnt_o,
  input  logic                     cnt_clr_i
);

  localparam int unsigned          PW       = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;
  localparam logic [PW-1:0]        LAST     = PW'(SCRUB_PERIOD - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam int                   HALF     = int'(K_MMR / 2);

  logic [K_MMR*WIDTH-1:0] copies_q, copies_d;
  logic [PW-1:0]          period_q;
  logic                   pending_q;
  logic                   ack_q;
  logic                   mismatch_q;
  logic [CNT_WIDTH-1:0]   cnt_q;

  logic [WIDTH-1:0]       voted;
  logic                   differ;
  logic                   periodic_due;
  logic                   forced_fire;
  logic                   scrub;

  // Bitwise majority: bit b is 1 when more than half of the copies hold a 1.
  always_comb begin
    int ones;
    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path leaves it holding its old value and no latch is inferred.
    voted = '0;
    ones  = 0;
    for (int b = 0; b < int'(WIDTH); b++) begin
      ones = 0;
      for (int k = 0; k < int'(K_MMR); k++) begin
        ones = ones + int'(copies_q[k*WIDTH + b]);
      end
      voted[b] = (ones > HALF);
    end
  end

  always_comb begin
    differ = 1'b0;
    for (int k = 0; k < int'(K_MMR); k++) begin
      if (copies_q[k*WIDTH +: WIDTH] != voted) differ = 1'b1;
    end
  end

  // A periodic scrub is due at terminal count, or left over from an edge where
  // a write blocked it. A forced request is ignored during its own ack cycle so
  // a requester still holding the level sees a clean one-cycle ack before a
  // new request is taken.
  assign periodic_due = (period_q == LAST) || pending_q;
  assign forced_fire  = scrub_req_i && !ack_q && !wr_en_i;
  assign scrub        = !wr_en_i && (periodic_due || forced_fire);

  always_comb begin
    copies_d = copies_q;
    if (wr_en_i)             copies_d = {K_MMR{wr_data_i}};
    else if (scrub)          copies_d = {K_MMR{voted}};
    else if (fault_inj_en_i) copies_d = copies_q ^ fault_inj_mask_i;
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      copies_q   <= {K_MMR{RESET_VALUE}};
      period_q   <= '0;
      pending_q  <= 1'b0;
      ack_q      <= 1'b0;
      mismatch_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      copies_q   <= copies_d;
      pending_q  <= wr_en_i && periodic_due;
      ack_q      <= forced_fire;
      mismatch_q <= differ;

      // A forced scrub (alone or merged with a periodic one) restarts the period.
      if (forced_fire || period_q == LAST) period_q <= '0;
      else                                 period_q <= period_q + 1'b1;

      if (cnt_clr_i)                                  cnt_q <= '0;
      else if (scrub && differ && cnt_q != CNT_MAX)   cnt_q <= cnt_q + 1'b1;
    end
  end

  assign data_o      = copies_q;
  assign voted_o     = voted;
  assign mismatch_o  = mismatch_q;
  assign corr_cnt_o  = cnt_q;
  assign scrub_ack_o = ack_q;

endmodule
